// File: rtl/stack_ctrl.sv
// stack_ctrl: push/pop sequencer between the datapath, the stack pointer
// register and a synchronous stack RAM (one-cycle read latency).
// The stack grows downward from STACK_TOP, one word per entry.
// Optional feature: define STACK_BOUNDS_CHECK_EN to reject a push at
// STACK_LIMIT-1 (overflow) and a pop at STACK_TOP (underflow).
// Outputs come from registers loaded with the values for the next state.
// The only exception is SP_CE, which is also gated by PRESET.
module stack_ctrl #(
    parameter int unsigned    W           = 16,
    parameter logic [W-1:0]   STACK_TOP   = 16'hF3FF,
    parameter logic [W-1:0]   STACK_LIMIT = 16'hF000
) (
    input  logic         CLK,
    input  logic         PRESET,
    input  logic         PUSH,
    input  logic         POP,
    input  logic [W-1:0] PUSH_DATA,
    input  logic [W-1:0] SP,
    output logic [W-1:0] newSP,
    output logic         SP_CE,
    output logic [W-1:0] MEM_ADDR,
    output logic [W-1:0] MEM_DIN,
    output logic         MEM_WE,
    output logic         MEM_RE,
    input  logic [W-1:0] MEM_DOUT,
    output logic [W-1:0] POP_DATA,
    output logic         BUSY,
    output logic         DONE,
    output logic         ERR
);

`ifdef STACK_BOUNDS_CHECK_EN
    localparam logic BOUNDS_EN = 1'b1;
`else
    localparam logic BOUNDS_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RWAIT,
        S_FIN,
        S_FAIL
    } state_e;

    state_e       state_q, state_d;
    logic [W-1:0] new_sp_q, new_sp_d;
    logic         sp_ce_q, sp_ce_d;
    logic [W-1:0] mem_addr_q, mem_addr_d;
    logic [W-1:0] mem_din_q, mem_din_d;
    logic         mem_we_q, mem_we_d;
    logic         mem_re_q, mem_re_d;
    logic [W-1:0] pop_data_q, pop_data_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic         ovf_c, unf_c;

    // Bounds violations against the live pointer. They are forced low when
    // the check is not built in.
    assign ovf_c = BOUNDS_EN && (SP == STACK_LIMIT - W'(1));
    assign unf_c = BOUNDS_EN && (SP == STACK_TOP);

    // Next-state decode, and the output values for the state being entered.
    // The output registers that are loaded on accept hold the latched
    // pointer and data for the WRITE/READ cycle.
    always_comb begin
        state_d    = state_q;
        new_sp_d   = '0;
        sp_ce_d    = 1'b0;
        mem_addr_d = '0;
        mem_din_d  = '0;
        mem_we_d   = 1'b0;
        mem_re_d   = 1'b0;
        pop_data_d = pop_data_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (PUSH && POP) begin
                    state_d = S_FAIL;
                    err_d   = 1'b1;
                end else if (PUSH) begin
                    if (ovf_c) begin
                        state_d = S_FAIL;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = S_WRITE;
                        mem_we_d   = 1'b1;
                        mem_addr_d = SP;
                        mem_din_d  = PUSH_DATA;
                        sp_ce_d    = 1'b1;
                        new_sp_d   = SP - W'(1);
                    end
                end else if (POP) begin
                    if (unf_c) begin
                        state_d = S_FAIL;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = S_READ;
                        mem_re_d   = 1'b1;
                        mem_addr_d = SP + W'(1);
                        sp_ce_d    = 1'b1;
                        new_sp_d   = SP + W'(1);
                    end
                end
            end
            S_WRITE: begin
                state_d = S_FIN;
                done_d  = 1'b1;
            end
            S_READ: begin
                state_d = S_RWAIT;
            end
            S_RWAIT: begin
                state_d    = S_FIN;
                done_d     = 1'b1;
                pop_data_d = MEM_DOUT;
            end
            S_FIN:   state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous preset.
    always_ff @(posedge CLK) begin
        if (PRESET) begin
            state_q    <= S_IDLE;
            new_sp_q   <= '0;
            sp_ce_q    <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_we_q   <= 1'b0;
            mem_re_q   <= 1'b0;
            pop_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            new_sp_q   <= new_sp_d;
            sp_ce_q    <= sp_ce_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_we_q   <= mem_we_d;
            mem_re_q   <= mem_re_d;
            pop_data_q <= pop_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // The pointer register presets on the same edge, so a load is withheld.
    assign SP_CE    = sp_ce_q & ~PRESET;
    assign newSP    = new_sp_q;
    assign MEM_ADDR = mem_addr_q;
    assign MEM_DIN  = mem_din_q;
    assign MEM_WE   = mem_we_q;
    assign MEM_RE   = mem_re_q;
    assign POP_DATA = pop_data_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: pointer register and stack RAM around the DUT. A
// transaction-level stack model predicts the per-cycle outputs of each
// operation, and a compare process checks every cycle against it.
module tb_stack_ctrl;

    logic        CLK;
    logic        PRESET;
    logic        PUSH;
    logic        POP;
    logic [15:0] PUSH_DATA;
    logic [15:0] SP;
    logic [15:0] newSP;
    logic        SP_CE;
    logic [15:0] MEM_ADDR;
    logic [15:0] MEM_DIN;
    logic        MEM_WE;
    logic        MEM_RE;
    logic [15:0] MEM_DOUT;
    logic [15:0] POP_DATA;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    stack_ctrl dut (
        .CLK(CLK), .PRESET(PRESET), .PUSH(PUSH), .POP(POP),
        .PUSH_DATA(PUSH_DATA), .SP(SP), .newSP(newSP), .SP_CE(SP_CE),
        .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN), .MEM_WE(MEM_WE),
        .MEM_RE(MEM_RE), .MEM_DOUT(MEM_DOUT), .POP_DATA(POP_DATA),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Environment: the stack pointer register, which the bench can also load
    // directly, and the synchronous stack RAM.
    logic [15:0] sp_reg;
    logic        tb_ld;
    logic [15:0] tb_ld_val;
    logic [15:0] ram [0:65535];

    assign SP = sp_reg;

    always @(posedge CLK) begin
        if (PRESET)     sp_reg <= 16'hF3FF;
        else if (tb_ld) sp_reg <= tb_ld_val;
        else if (SP_CE) sp_reg <= newSP;
    end

    always @(posedge CLK) begin
        if (MEM_WE) ram[MEM_ADDR] <= MEM_DIN;
        if (MEM_RE) MEM_DOUT <= ram[MEM_ADDR];
    end

    // Expected output set for one cycle.
    typedef struct packed {
        logic        we;
        logic        re;
        logic        ce;
        logic        busy;
        logic        done;
        logic        err;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] nsp;
        logic [15:0] pd;
    } rec_t;

    rec_t        exp_q[$];
    logic [15:0] m_mem [0:65535];
    logic [15:0] m_sp;
    logic [15:0] m_pd;
    bit          chk_en;
    int          n_pass;
    int          n_total;

    function automatic rec_t mk(input logic we, input logic re, input logic ce,
                                input logic busy, input logic done, input logic err,
                                input logic [15:0] addr, input logic [15:0] din,
                                input logic [15:0] nsp, input logic [15:0] pd);
        rec_t r;
        r.we = we; r.re = re; r.ce = ce; r.busy = busy; r.done = done; r.err = err;
        r.addr = addr; r.din = din; r.nsp = nsp; r.pd = pd;
        return r;
    endfunction

    function automatic rec_t act_rec();
        return mk(MEM_WE, MEM_RE, SP_CE, BUSY, DONE, ERR, MEM_ADDR, MEM_DIN, newSP, POP_DATA);
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    // Per-cycle comparison: queued expectation, or idle outputs when none.
    initial begin
        rec_t e;
        bit   idle;
        forever begin
            @(posedge CLK);
            #1;
            if (chk_en) begin
                idle = (exp_q.size() == 0);
                if (idle) e = mk(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, m_pd);
                else      e = exp_q.pop_front();
                chk(idle ? "idle_outputs" : "op_outputs", 80'(act_rec()), 80'(e));
                if (idle) chk("sp_register", 80'(sp_reg), 80'(m_sp));
            end
        end
    end

    // Issue one request and record what the stack model says must follow.
    // With hold set, PUSH and POP are both held high while the DUT is busy.
    task automatic op(input logic push, input logic pop, input logic [15:0] d, input bit hold);
        logic        rej;
        logic [15:0] s;
        logic [15:0] v;
        int          n;
        @(negedge CLK);
        PUSH = push; POP = pop; PUSH_DATA = d;
        s   = m_sp;
        rej = push && pop;
`ifdef STACK_BOUNDS_CHECK_EN
        if (push && !pop && s == 16'hEFFF) rej = 1'b1;
        if (pop && !push && s == 16'hF3FF) rej = 1'b1;
`endif
        n = 1;
        if (rej) begin
            exp_q.push_back(mk(0, 0, 0, 1, 0, 1, 16'h0, 16'h0, 16'h0, m_pd));
        end else if (push) begin
            exp_q.push_back(mk(1, 0, 1, 1, 0, 0, s, d, s - 16'd1, m_pd));
            exp_q.push_back(mk(0, 0, 0, 1, 1, 0, 16'h0, 16'h0, 16'h0, m_pd));
            m_mem[s] = d;
            m_sp = s - 16'd1;
            n = 2;
        end else if (pop) begin
            v = m_mem[16'(s + 16'd1)];
            exp_q.push_back(mk(0, 1, 1, 1, 0, 0, s + 16'd1, 16'h0, s + 16'd1, m_pd));
            exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 16'h0, 16'h0, 16'h0, m_pd));
            exp_q.push_back(mk(0, 0, 0, 1, 1, 0, 16'h0, 16'h0, 16'h0, v));
            m_pd = v;
            m_sp = s + 16'd1;
            n = 3;
        end
        @(negedge CLK);
        if (hold && n > 1) begin PUSH = 1'b1; POP = 1'b1; end
        else begin PUSH = 1'b0; POP = 1'b0; end
        for (int i = 1; i < n; i++) @(negedge CLK);
        PUSH = 1'b0; POP = 1'b0;
    endtask

    task automatic load_sp(input logic [15:0] v);
        @(negedge CLK);
        tb_ld = 1'b1; tb_ld_val = v; m_sp = v;
        @(negedge CLK);
        tb_ld = 1'b0;
    endtask

    initial begin
        n_pass = 0; n_total = 0; chk_en = 0;
        PRESET = 1'b1; PUSH = 1'b0; POP = 1'b0; PUSH_DATA = 16'h0;
        tb_ld = 1'b0; tb_ld_val = 16'h0;
        m_sp = 16'hF3FF; m_pd = 16'h0;
        repeat (3) @(negedge CLK);
        chk("reset_outputs", 80'(act_rec()), 80'h0);
        chk("reset_sp", 80'(sp_reg), 80'h0000_F3FF);
        PRESET = 1'b0;
        chk_en = 1;

        // Single push, DONE two cycles after accept, then pop it back.
        op(1, 0, 16'hA5A5, 0);
        chk("push_done", 80'(DONE), 80'h1);
        chk("push_sp", 80'(sp_reg), 80'h0000_F3FE);
        op(0, 1, 16'h0, 0);
        chk("pop_done", 80'(DONE), 80'h1);
        chk("pop_data_a5a5", 80'(POP_DATA), 80'h0000_A5A5);

        // Round trip; requests during busy cycles are ignored.
        op(1, 0, 16'h1234, 0);
        op(1, 0, 16'h5678, 1);
        op(0, 1, 16'h0, 1);
        chk("pop_data_5678", 80'(POP_DATA), 80'h0000_5678);
        op(0, 1, 16'h0, 0);
        chk("pop_data_1234", 80'(POP_DATA), 80'h0000_1234);
        chk("round_trip_sp", 80'(sp_reg), 80'h0000_F3FF);

        // Simultaneous request.
        op(1, 1, 16'hDEAD, 0);
        chk("both_err", 80'(ERR), 80'h1);
        chk("both_sp", 80'(sp_reg), 80'h0000_F3FF);

`ifdef STACK_BOUNDS_CHECK_EN
        op(0, 1, 16'h0, 0);
        chk("underflow_err", 80'(ERR), 80'h1);
        chk("underflow_sp", 80'(sp_reg), 80'h0000_F3FF);
`endif

        // Overflow boundary and the last legal push.
        load_sp(16'hEFFF);
        op(1, 0, 16'h0BAD, 0);
`ifdef STACK_BOUNDS_CHECK_EN
        chk("overflow_err", 80'(ERR), 80'h1);
        chk("overflow_sp", 80'(sp_reg), 80'h0000_EFFF);
`else
        chk("below_limit_done", 80'(DONE), 80'h1);
        chk("below_limit_sp", 80'(sp_reg), 80'h0000_EFFE);
`endif
        load_sp(16'hF000);
        op(1, 0, 16'h0F00, 0);
        chk("limit_push_sp", 80'(sp_reg), 80'h0000_EFFF);

        // Modulo wrap in both directions.
        load_sp(16'h0000);
        op(1, 0, 16'hC0DE, 0);
        chk("wrap_push_sp", 80'(sp_reg), 80'h0000_FFFF);
        op(0, 1, 16'h0, 0);
        chk("wrap_pop_data", 80'(POP_DATA), 80'h0000_C0DE);
        chk("wrap_pop_sp", 80'(sp_reg), 80'h0000_0000);

        // Preset during RWAIT of a pop.
        load_sp(16'hF3FF);
        op(1, 0, 16'hBEEF, 0);
        op(1, 0, 16'hCAFE, 0);
        @(negedge CLK);
        POP = 1'b1;
        exp_q.push_back(mk(0, 1, 1, 1, 0, 0, 16'hF3FE, 16'h0, 16'hF3FE, m_pd));
        exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 16'h0, 16'h0, 16'h0, m_pd));
        m_pd = 16'h0; m_sp = 16'hF3FF;
        @(negedge CLK);
        POP = 1'b0;
        @(negedge CLK);
        PRESET = 1'b1;
        @(negedge CLK);
        PRESET = 1'b0;
        chk("rst_pop_done", 80'(DONE), 80'h0);
        chk("rst_pop_busy", 80'(BUSY), 80'h0);
        chk("rst_pop_data", 80'(POP_DATA), 80'h0);
        chk("rst_pop_sp", 80'(sp_reg), 80'h0000_F3FF);

        // Preset during WRITE: the pointer load enable is withheld.
        @(negedge CLK);
        PUSH = 1'b1; PUSH_DATA = 16'h7777;
        exp_q.push_back(mk(1, 0, 1, 1, 0, 0, 16'hF3FF, 16'h7777, 16'hF3FE, m_pd));
        m_mem[16'hF3FF] = 16'h7777;
        @(negedge CLK);
        PUSH = 1'b0;
        PRESET = 1'b1;
        #1;
        chk("rst_write_ce", 80'(SP_CE), 80'h0);
        @(negedge CLK);
        PRESET = 1'b0;
        chk("rst_write_done", 80'(DONE), 80'h0);
        chk("rst_write_sp", 80'(sp_reg), 80'h0000_F3FF);

        // Normal operation after preset.
        op(1, 0, 16'h4242, 0);
        op(0, 1, 16'h0, 0);
        chk("recover_data", 80'(POP_DATA), 80'h0000_4242);
        chk("recover_sp", 80'(sp_reg), 80'h0000_F3FF);

        repeat (3) @(negedge CLK);
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Push/pop sequencer that sits between the datapath and the stack pointer register: it consumes the current stack pointer, drives the stack RAM port, and returns the updated pointer with a load enable. The stack pointer register itself only holds `SP` and loads `newSP` on `CE`. `stack_ctrl` is the only block that generates `newSP`/`CE` for stack operations. The stack grows downward from 16'hF3FF, one 16-bit word per entry, over a synchronous RAM with one-cycle read latency.

## Interface
- `STACK_TOP`, 16'hF3FF: empty-stack pointer value; must match the pointer register's preset value.
- `STACK_LIMIT`, 16'hF000: lowest writable address; a push with `SP == STACK_LIMIT - 1` is an overflow.
- `CLK` input 1: single clock, rising edge.
- `PRESET` input 1: reset, synchronous, active-high.
- `PUSH` input 1: push request, sampled in IDLE only.
- `POP` input 1: pop request, sampled in IDLE only.
- `PUSH_DATA` input 16: word to push, captured on accept.
- `SP` input 16: current stack pointer from the pointer register.
- `newSP` output 16: next pointer value to the pointer register.
- `SP_CE` output 1: load enable to the pointer register; one-cycle pulse.
- `MEM_ADDR` output 16: stack RAM address.
- `MEM_DIN` output 16: stack RAM write data.
- `MEM_WE` output 1: stack RAM write strobe.
- `MEM_RE` output 1: stack RAM read strobe.
- `MEM_DOUT` input 16: stack RAM read data, valid one cycle after `MEM_RE`.
- `POP_DATA` output 16: last popped word; held until the next successful pop.
- `BUSY` output 1: high in any state other than IDLE.
- `DONE` output 1: one-cycle pulse when an operation completes.
- `ERR` output 1: one-cycle pulse, in place of `DONE`, when a request is rejected.

## Operation
- States: IDLE, WRITE, READ, RWAIT, FIN, FAIL.
- IDLE behaviour:
  - `PUSH` only: capture `PUSH_DATA` and `SP` into internal registers, then go to WRITE.
  - `POP` only: capture `SP`, then go to READ.
  - `PUSH` and `POP` together: go to FAIL. Neither operation is performed.
- WRITE (push):
  - Drive `MEM_WE=1`, `MEM_ADDR=spq`, `MEM_DIN=dq`.
  - Drive `SP_CE=1`, `newSP=spq-1`.
  - Go to FIN.
- READ (pop):
  - Drive `MEM_RE=1`, `MEM_ADDR=spq+1`.
  - Drive `SP_CE=1`, `newSP=spq+1`.
  - Go to RWAIT.
- RWAIT: register `MEM_DOUT` into `POP_DATA`, then go to FIN.
- FIN: `DONE=1`, then go to IDLE.
- FAIL: `ERR=1`, then go to IDLE.
- All memory and pointer addresses use the latched `spq`, never the live `SP`. The live `SP` changes at the end of the WRITE/READ cycle.
- Arithmetic is 16-bit modulo 2^16. 16'h0000-1 gives 16'hFFFF, and 16'hFFFF+1 gives 16'h0000. Carries are discarded.
- `PUSH` and `POP` are ignored whenever `BUSY=1`. They are not queued.
- Outputs not driven by the current state are 0. `MEM_ADDR`, `MEM_DIN` and `newSP` are also 0 when their strobe is low.

## Timing
- Accept is at edge 0, counted from the rising edge where IDLE samples the request.
- Push: WRITE occupies cycle 1, `DONE` is high in cycle 2, and the pointer register holds `spq-1` from cycle 2 on. Push latency to `DONE` is 2 cycles.
- Pop: READ occupies cycle 1, RWAIT occupies cycle 2, `DONE` is high in cycle 3, and `POP_DATA` is valid from cycle 3 on. Pop latency to `DONE` is 3 cycles.
- Back-to-back: a new request can be accepted in the cycle after `DONE` or `ERR`. The minimum push-to-push period is 3 cycles.
- Reset values: state IDLE, `POP_DATA`=16'h0000, and every other output 0.
- `PRESET` mid-operation:
  - Aborts to IDLE on the next edge. No `DONE` or `ERR` is produced.
  - `SP_CE` is suppressed in the reset cycle.
  - The pointer register presets to `STACK_TOP` on the same edge, so the stack is consistently empty afterwards.

## Configuration
- `STACK_BOUNDS_CHECK_EN` defined: the check is made in IDLE against the live `SP`.
  - A push with `SP == STACK_LIMIT-1` goes to FAIL (overflow).
  - A pop with `SP == STACK_TOP` goes to FAIL (underflow).
  - No memory or pointer activity occurs on a rejected request.
- `STACK_BOUNDS_CHECK_EN` undefined: no bounds check; pointers wrap modulo 2^16. `ERR` is produced only for simultaneous `PUSH` and `POP`.

## Test plan
- Single push: after `PRESET` with `SP`=F3FF, push A5A5 -> cycle 1 `MEM_WE=1`, `MEM_ADDR`=F3FF, `MEM_DIN`=A5A5, `SP_CE=1`, `newSP`=F3FE. Cycle 2 `DONE=1`.
- Push then pop round trip: push 1234, then push 5678, then two pops -> `POP_DATA`=5678 then 1234, and `SP` returns to F3FF. Each pop reads from `spq+1`.
- Simultaneous request: `PUSH=POP=1` in IDLE -> `ERR=1` in cycle 1, no `MEM_WE`/`MEM_RE`/`SP_CE`, `SP` unchanged.
- Bounds (macro defined):
  - Pop at `SP`=F3FF -> `ERR` in cycle 1, `SP` unchanged.
  - Push at `SP`=EFFF -> `ERR`.
  - Push at `SP`=F000 -> succeeds with `newSP`=EFFF.
- Wrap (macro undefined): push at `SP`=0000 -> `newSP`=FFFF. Pop at `SP`=FFFF -> `MEM_ADDR`=0000, `newSP`=0000.
- Reset mid-pop: assert `PRESET` during RWAIT -> next cycle IDLE, no `DONE`, `POP_DATA`=0000, `BUSY=0`, and the pointer register reads F3FF.
